u409_pci_initiator: RTL and testbench

Single-data-phase PCI initiator driving the PCI bus on behalf of the 68040 side of the AmigaPCI bridge. Accepts a latched, already-decoded CPU access, which carries the address, access type, direction, byte enables and write data. Runs one PCI address phase and one data phase with the matching bus command. Returns completion, retry or abort status plus read data to the CPU-side cycle logic.

---
 rtl/u409_pci_initiator_if.sv | 39 +++
 rtl/u409_pci_initiator.sv | 176 +++++++++++++++++
 tb/tb_u409_pci_initiator.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/u409_pci_initiator_if.sv
// Bus bundle between the u409 PCI initiator and its surroundings: the latched
// CPU request, the PCI master drive/enable pair for each line, target responses and status.
interface u409_pci_initiator_if;
    logic        START;
    logic [31:0] A;
    logic [1:0]  PCIAT;
    logic        RnW;
    logic [3:0]  BEn;
    logic [31:0] WDATA;
    logic        GNTn;
    logic        DEVSELn;
    logic        TRDYn;
    logic        STOPn;
    logic [31:0] AD_IN;
    logic [31:0] AD_OUT;
    logic        AD_OE;
    logic [3:0]  CBE_OUT;
    logic        CBE_OE;
    logic        FRAMEn_OUT;
    logic        IRDYn_OUT;
    logic        CTRL_OE;
    logic [31:0] RDATA;
    logic        BUSY;
    logic        DONE;
    logic        RETRY;
    logic        ERR;

    modport master (
        input  START, A, PCIAT, RnW, BEn, WDATA, GNTn, DEVSELn, TRDYn, STOPn, AD_IN,
        output AD_OUT, AD_OE, CBE_OUT, CBE_OE, FRAMEn_OUT, IRDYn_OUT, CTRL_OE,
               RDATA, BUSY, DONE, RETRY, ERR
    );

    modport slave (
        output START, A, PCIAT, RnW, BEn, WDATA, GNTn, DEVSELn, TRDYn, STOPn, AD_IN,
        input  AD_OUT, AD_OE, CBE_OUT, CBE_OE, FRAMEn_OUT, IRDYn_OUT, CTRL_OE,
               RDATA, BUSY, DONE, RETRY, ERR
    );
endinterface

// File: rtl/u409_pci_initiator.sv
// Single-data-phase PCI initiator for the 68040 side of the AmigaPCI bridge:
// one address phase, one data phase, then completion/retry/abort status back to the CPU side.
module u409_pci_initiator #(
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic                    PCICLK,
    input  logic                    RESET,
    u409_pci_initiator_if.master    bus
);
    localparam logic [3:0] TMO = 4'(DEVSEL_TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_WAITGNT, S_ADDR, S_DATA, S_TURN} state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  at_q;
    logic        rnw_q;
    logic [3:0]  ben_q;
    logic [3:0]  cnt;
    logic        seen;

    logic [31:0] ad_out;
    logic [31:0] rdata;
    logic [3:0]  cbe_out;
    logic        ad_oe;
    logic        cbe_oe;
    logic        ctrl_oe;
    logic        frame_n;
    logic        irdy_n;
    logic        busy;
    logic        done;
    logic        retry;
    logic        err;

    logic [31:0] addr_phase;
    logic [3:0]  cmd;
    logic        m_abort;
    logic        t_abort;
    logic        xfer;
    logic        t_retry;
    logic        finish;

    // Address-phase AD[1:0] and bus command, both derived from the access type
    always_comb begin
        addr_phase = addr_q;
        cmd        = 4'b0110;
        case (at_q)
            2'b00: begin
                addr_phase = {addr_q[31:2], 2'b00};
                cmd        = {3'b101, ~rnw_q};
            end
            2'b01: begin
                addr_phase = {addr_q[31:2], 2'b01};
                cmd        = {3'b101, ~rnw_q};
            end
            2'b10: begin
                addr_phase = {addr_q[31:2], 2'b00};
                cmd        = {3'b011, ~rnw_q};
            end
            default: begin
                addr_phase = addr_q;
                cmd        = {3'b001, ~rnw_q};
            end
        endcase
    end

    // Data-phase exit conditions in priority order; TRDY wins over STOP
    assign m_abort = (cnt == TMO) && !seen;
    assign t_abort = !bus.STOPn && bus.DEVSELn && seen;
    assign xfer    = !bus.TRDYn && !bus.DEVSELn;
    assign t_retry = !bus.STOPn && bus.TRDYn && !bus.DEVSELn;
    assign finish  = m_abort || t_abort || xfer || t_retry;

    always_ff @(posedge PCICLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            ad_out  <= '0;
            cbe_out <= 4'hF;
            ad_oe   <= 1'b0;
            cbe_oe  <= 1'b0;
            ctrl_oe <= 1'b0;
            frame_n <= 1'b1;
            irdy_n  <= 1'b1;
            rdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            retry   <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
            seen    <= 1'b0;
        end else begin
            done  <= 1'b0;
            retry <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        addr_q  <= bus.A;
                        at_q    <= bus.PCIAT;
                        rnw_q   <= bus.RnW;
                        ben_q   <= bus.BEn;
                        wdata_q <= bus.WDATA;
                        busy    <= 1'b1;
                        state   <= S_WAITGNT;
                    end
                end
                S_WAITGNT: begin
                    if (!bus.GNTn) begin
                        state   <= S_ADDR;
                        frame_n <= 1'b0;
                        irdy_n  <= 1'b1;
                        ad_oe   <= 1'b1;
                        cbe_oe  <= 1'b1;
                        ctrl_oe <= 1'b1;
                        ad_out  <= addr_phase;
                        cbe_out <= cmd;
                    end
                end
                S_ADDR: begin
                    state   <= S_DATA;
                    frame_n <= 1'b1;
                    irdy_n  <= 1'b0;
                    cbe_out <= ben_q;
                    ad_oe   <= ~rnw_q;
                    if (!rnw_q) ad_out <= wdata_q;
                    cnt     <= '0;
                    seen    <= 1'b0;
                end
                S_DATA: begin
                    if (finish) begin
                        state  <= S_TURN;
                        irdy_n <= 1'b1;
                        ad_oe  <= 1'b0;
                        cbe_oe <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        if (m_abort) begin
                            err <= 1'b1;
                            if (rnw_q) rdata <= '1;
                        end else if (t_abort) begin
                            err <= 1'b1;
                        end else if (xfer) begin
                            if (rnw_q) rdata <= bus.AD_IN;
                        end else begin
                            retry <= 1'b1;
                        end
                    end else begin
                        if (bus.DEVSELn && cnt != 4'hF) cnt <= cnt + 4'd1;
                        if (!bus.DEVSELn) seen <= 1'b1;
                    end
                end
                S_TURN: begin
                    state   <= S_IDLE;
                    ctrl_oe <= 1'b0;
                    frame_n <= 1'b1;
                    irdy_n  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.AD_OUT     = ad_out;
    assign bus.AD_OE      = ad_oe;
    assign bus.CBE_OUT    = cbe_out;
    assign bus.CBE_OE     = cbe_oe;
    assign bus.FRAMEn_OUT = frame_n;
    assign bus.IRDYn_OUT  = irdy_n;
    assign bus.CTRL_OE    = ctrl_oe;
    assign bus.RDATA      = rdata;
    assign bus.BUSY       = busy;
    assign bus.DONE       = done;
    assign bus.RETRY      = retry;
    assign bus.ERR        = err;
endmodule

// File: tb/tb_u409_pci_initiator.sv
// Self-checking bench for u409_pci_initiator: directed vector table, randomized
// transactions against a transaction-level reference model, and reset corner cases.
module tb_u409_pci_initiator;
    localparam int T = 5;
    localparam int NR = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    u409_pci_initiator_if bus ();

    u409_pci_initiator #(.DEVSEL_TIMEOUT(T)) dut (
        .PCICLK (clk),
        .RESET  (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [1:0]  at;
        logic        rnw;
        logic [31:0] addr;
        logic [3:0]  ben;
        logic [31:0] wdata;
        logic [31:0] rdv;
        int          gd;
        bit          dup;
        int          f;
        int          w;
        int          term;
        logic [31:0] e_ad;
        logic [3:0]  e_cbe;
        int          e_after;
        logic        e_retry;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    logic rd_devs [NR];
    logic rd_trdy [NR];
    logic rd_stop [NR];
    logic [31:0] prev_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Target behaviour per DATA clock: f clocks without DEVSEL, w wait states, then the terminal response
    task automatic build_resp(input int f, input int w_in, input int term, input bit noise);
        int w;
        w = (term == 3 && w_in == 0) ? 1 : w_in;
        for (int k = 0; k < NR; k++) begin
            if (k < f) begin
                rd_devs[k] = 1'b1;
                rd_trdy[k] = noise ? 1'($urandom) : 1'b1;
                rd_stop[k] = noise ? 1'($urandom) : 1'b1;
            end else if (k < f + w) begin
                rd_devs[k] = 1'b0; rd_trdy[k] = 1'b1; rd_stop[k] = 1'b1;
            end else begin
                case (term)
                    0: begin rd_devs[k] = 1'b0; rd_trdy[k] = 1'b0; rd_stop[k] = 1'b1; end
                    1: begin rd_devs[k] = 1'b0; rd_trdy[k] = 1'b1; rd_stop[k] = 1'b0; end
                    2: begin rd_devs[k] = 1'b0; rd_trdy[k] = 1'b0; rd_stop[k] = 1'b0; end
                    default: begin rd_devs[k] = 1'b1; rd_trdy[k] = 1'b1; rd_stop[k] = 1'b0; end
                endcase
            end
        end
    endtask

    function automatic logic [31:0] ref_ad(input logic [1:0] at, input logic [31:0] a);
        case (at)
            2'b00, 2'b10: return a & 32'hFFFF_FFFC;
            2'b01:        return (a & 32'hFFFF_FFFC) | 32'h1;
            default:      return a;
        endcase
    endfunction

    function automatic logic [3:0] ref_cmd(input logic [1:0] at, input logic rnw);
        case (at)
            2'b00, 2'b01: return rnw ? 4'hA : 4'hB;
            2'b10:        return rnw ? 4'h6 : 4'h7;
            default:      return rnw ? 4'h2 : 4'h3;
        endcase
    endfunction

    // Outcome of a whole data phase, judged from the response timeline
    task automatic ref_outcome(input logic rnw, input logic [31:0] rdv, input logic [31:0] prev,
                               output int after, output logic retry, output logic err,
                               output logic [31:0] rdata);
        int first;
        first = -1;
        after = -1; retry = 1'b0; err = 1'b0; rdata = prev;
        for (int k = 0; k < T; k++)
            if (first < 0 && !rd_devs[k]) first = k;
        if (first < 0) begin
            after = T + 1; err = 1'b1;
            if (rnw) rdata = 32'hFFFF_FFFF;
        end else begin
            for (int k = first; k < NR && after < 0; k++) begin
                if (!rd_devs[k] && !rd_trdy[k]) begin
                    after = k + 1;
                    if (rnw) rdata = rdv;
                end else if (!rd_devs[k] && !rd_stop[k]) begin
                    after = k + 1; retry = 1'b1;
                end else if (rd_devs[k] && !rd_stop[k] && k > first) begin
                    after = k + 1; err = 1'b1;
                end
            end
        end
    endtask

    task automatic idle_target();
        bus.DEVSELn = 1'b1; bus.TRDYn = 1'b1; bus.STOPn = 1'b1;
    endtask

    task automatic run_txn(input logic [1:0] at, input logic rnw, input logic [31:0] addr,
                           input logic [3:0] ben, input logic [31:0] wdata, input logic [31:0] rdv,
                           input int gd, input bit dup, input logic [31:0] e_ad, input logic [3:0] e_cbe,
                           input int e_after, input logic e_retry, input logic e_err,
                           input logic [31:0] e_rdata);
        int addr_i, dcnt;
        bit got_done, wait_bad, qual_bad;
        @(posedge clk); #1;
        bus.START = 1'b1; bus.A = addr; bus.PCIAT = at; bus.RnW = rnw;
        bus.BEn = ben; bus.WDATA = wdata; bus.GNTn = 1'($urandom);
        bus.AD_IN = $urandom;
        idle_target();
        addr_i = -1; dcnt = 0; got_done = 0; wait_bad = 0; qual_bad = 0;
        for (int i = 1; i <= 60 && !got_done; i++) begin
            @(posedge clk); #1;
            bus.START = dup && i == 3;
            if (dup && i == 3) begin bus.A = ~addr; bus.RnW = ~rnw; bus.BEn = ~ben; end
            if (i <= gd) bus.GNTn = 1'b1;
            else if (i == gd + 1) bus.GNTn = 1'b0;
            else bus.GNTn = 1'($urandom);
            idle_target();
            bus.AD_IN = $urandom;
            if (i <= gd + 1)
                if (bus.AD_OE || bus.CBE_OE || bus.CTRL_OE || !bus.FRAMEn_OUT || !bus.IRDYn_OUT || !bus.BUSY)
                    wait_bad = 1;
            if (bus.CTRL_OE && !bus.FRAMEn_OUT) begin
                addr_i = i;
                chk("addr_ad", bus.AD_OUT, e_ad);
                chk("addr_cbe", bus.CBE_OUT, e_cbe);
                chk("addr_oe", {bus.AD_OE, bus.CBE_OE, bus.IRDYn_OUT}, 3'b111);
            end
            if (bus.CTRL_OE && !bus.IRDYn_OUT) begin
                if (dcnt == 0) begin
                    chk("data_cbe", {bus.CBE_OE, bus.CBE_OUT}, {1'b1, ben});
                    chk("data_ad_oe", bus.AD_OE, !rnw);
                    if (!rnw) chk("data_ad", bus.AD_OUT, wdata);
                end
                if (dcnt < NR) begin
                    bus.DEVSELn = rd_devs[dcnt]; bus.TRDYn = rd_trdy[dcnt]; bus.STOPn = rd_stop[dcnt];
                end
                bus.AD_IN = rdv;
                dcnt++;
            end
            if (bus.DONE) begin
                got_done = 1;
                chk("turn_drv", {bus.CTRL_OE, bus.AD_OE, bus.CBE_OE, bus.FRAMEn_OUT, bus.IRDYn_OUT, bus.BUSY},
                    6'b100110);
                chk("done_after", dcnt, e_after);
                chk("retry", bus.RETRY, e_retry);
                chk("err", bus.ERR, e_err);
                chk("rdata", bus.RDATA, e_rdata);
            end else if (bus.RETRY || bus.ERR) begin
                qual_bad = 1;
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        chk("addr_cycle", addr_i, gd + 2);
        chk("wait_state", wait_bad, 0);
        chk("status_qual", qual_bad, 0);
        @(posedge clk); #1;
        idle_target();
        chk("idle_after", {bus.DONE, bus.AD_OE, bus.CBE_OE, bus.CTRL_OE, bus.BUSY}, 5'b0);
    endtask

    vec_t tbl [13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int after;
        logic e_retry, e_err;
        logic [31:0] e_rdata, a;
        logic [1:0] at;
        logic rnw;
        bit found;

        tbl[0]  = '{2'b10, 1'b1, 32'h4000_1234, 4'h0, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 0, 0, 0,
                    32'h4000_1234, 4'h6, 1, 1'b0, 1'b0, 32'hCAFE_F00D};
        tbl[1]  = '{2'b01, 1'b0, 32'hFDA0_0804, 4'h0, 32'h1234_5678, 32'h0, 0, 1'b0, 0, 0, 0,
                    32'hFDA0_0805, 4'hB, 1, 1'b0, 1'b0, 32'hCAFE_F00D};
        tbl[2]  = '{2'b11, 1'b1, 32'h0000_1003, 4'h0, 32'h0, 32'h1111_1111, 0, 1'b0, 15, 0, 0,
                    32'h0000_1003, 4'h2, 6, 1'b0, 1'b1, 32'hFFFF_FFFF};
        tbl[3]  = '{2'b00, 1'b1, 32'h0000_0107, 4'h0, 32'h0, 32'h2222_2222, 0, 1'b0, 0, 1, 1,
                    32'h0000_0104, 4'hA, 2, 1'b1, 1'b0, 32'hFFFF_FFFF};
        tbl[4]  = '{2'b10, 1'b0, 32'h8000_0003, 4'h5, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 2, 0, 2,
                    32'h8000_0000, 4'h7, 3, 1'b0, 1'b0, 32'hFFFF_FFFF};
        tbl[5]  = '{2'b11, 1'b0, 32'h0000_0002, 4'hC, 32'h0000_00AA, 32'h0, 1, 1'b0, 1, 1, 3,
                    32'h0000_0002, 4'h3, 3, 1'b0, 1'b1, 32'hFFFF_FFFF};
        tbl[6]  = '{2'b10, 1'b1, 32'h1234_567B, 4'h0, 32'h0, 32'hA5A5_5A5A, 7, 1'b1, 1, 2, 2,
                    32'h1234_5678, 4'h6, 4, 1'b0, 1'b0, 32'hA5A5_5A5A};
        tbl[7]  = '{2'b01, 1'b1, 32'h0001_0003, 4'h3, 32'h0, 32'h0BAD_BEEF, 2, 1'b0, 3, 0, 0,
                    32'h0001_0001, 4'hA, 4, 1'b0, 1'b0, 32'h0BAD_BEEF};
        tbl[8]  = '{2'b10, 1'b0, 32'hC000_0000, 4'h0, 32'h5555_AAAA, 32'h0, 0, 1'b0, 15, 0, 0,
                    32'hC000_0000, 4'h7, 6, 1'b0, 1'b1, 32'h0BAD_BEEF};
        tbl[9]  = '{2'b10, 1'b1, 32'h0000_0010, 4'h0, 32'h0, 32'h5555_5555, 0, 1'b0, 0, 2, 3,
                    32'h0000_0010, 4'h6, 3, 1'b0, 1'b1, 32'h0BAD_BEEF};
        tbl[10] = '{2'b10, 1'b1, 32'h0000_0020, 4'h0, 32'h0, 32'h1111_2222, 0, 1'b0, 4, 0, 0,
                    32'h0000_0020, 4'h6, 5, 1'b0, 1'b0, 32'h1111_2222};
        tbl[11] = '{2'b10, 1'b1, 32'h0000_0030, 4'h0, 32'h0, 32'h3333_4444, 0, 1'b0, 0, 0, 2,
                    32'h0000_0030, 4'h6, 1, 1'b0, 1'b0, 32'h3333_4444};
        tbl[12] = '{2'b11, 1'b1, 32'h0000_0101, 4'h0, 32'h0, 32'h7777_7777, 0, 1'b0, 4, 0, 1,
                    32'h0000_0101, 4'h2, 5, 1'b1, 1'b0, 32'h3333_4444};

        bus.START = 1'b0; bus.A = '0; bus.PCIAT = '0; bus.RnW = 1'b0; bus.BEn = 4'hF;
        bus.WDATA = '0; bus.GNTn = 1'b1; bus.AD_IN = '0;
        idle_target();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ctrl", {bus.AD_OE, bus.CBE_OE, bus.CTRL_OE, bus.FRAMEn_OUT, bus.IRDYn_OUT,
                           bus.BUSY, bus.DONE, bus.RETRY, bus.ERR}, 9'b000110000);
        chk("reset_ad", bus.AD_OUT, 32'h0);
        chk("reset_cbe", bus.CBE_OUT, 4'hF);
        chk("reset_rdata", bus.RDATA, 32'h0);

        for (int v = 0; v < 13; v++) begin
            build_resp(tbl[v].f, tbl[v].w, tbl[v].term, 1'b0);
            run_txn(tbl[v].at, tbl[v].rnw, tbl[v].addr, tbl[v].ben, tbl[v].wdata, tbl[v].rdv,
                    tbl[v].gd, tbl[v].dup, tbl[v].e_ad, tbl[v].e_cbe, tbl[v].e_after,
                    tbl[v].e_retry, tbl[v].e_err, tbl[v].e_rdata);
        end
        prev_rdata = 32'h3333_4444;

        for (int n = 0; n < 40; n++) begin
            at = 2'($urandom);
            rnw = 1'($urandom);
            a = $urandom;
            build_resp($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
            ref_outcome(rnw, 32'h9000_0000 + n, prev_rdata, after, e_retry, e_err, e_rdata);
            run_txn(at, rnw, a, 4'($urandom), $urandom, 32'h9000_0000 + n, $urandom_range(0, 3), 1'b0,
                    ref_ad(at, a), ref_cmd(at, rnw), after, e_retry, e_err, e_rdata);
            prev_rdata = e_rdata;
        end

        // Reset in the middle of a write data phase
        @(posedge clk); #1;
        bus.START = 1'b1; bus.A = 32'h2000_0000; bus.PCIAT = 2'b10; bus.RnW = 1'b0;
        bus.BEn = 4'h0; bus.WDATA = 32'hFEED_FACE; bus.GNTn = 1'b0;
        idle_target();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk); #1;
            bus.START = 1'b0;
            if (bus.CTRL_OE && !bus.IRDYn_OUT) found = 1;
        end
        chk("reach_data", found, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_data_ctrl", {bus.AD_OE, bus.CBE_OE, bus.CTRL_OE, bus.FRAMEn_OUT, bus.IRDYn_OUT,
                              bus.BUSY, bus.DONE, bus.RETRY, bus.ERR}, 9'b000110000);
        chk("rst_data_rdata", bus.RDATA, 32'h0);
        found = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.DONE || bus.BUSY || bus.CTRL_OE) found = 1;
        end
        chk("rst_no_done", found, 0);

        build_resp(0, 0, 0, 1'b0);
        run_txn(2'b10, 1'b1, 32'h4000_0040, 4'h0, 32'h0, 32'h600D_DA7A, 0, 1'b0,
                32'h4000_0040, 4'h6, 1, 1'b0, 1'b0, 32'h600D_DA7A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
